alu_sequencer: RTL and testbench
================================

# alu_sequencer

Multi-cycle control sequencer that initiates each ALU operation on the CPU's shared-bus datapath. It accepts one register-to-register instruction (opcode plus Ra/Rb/Rc fields) and walks it through operand fetch into Y, ALU evaluation into Z, and write-back of Z-low into Ra. It drives the ALU's one-hot operation select lines and the register, Y and Z strobes, and reports completion to the instruction-level control.

## Interface

- No parameters. Widths are fixed by the datapath: 16 registers, 5-bit opcode, 10 ALU operations.
- clock  in  1  rising-edge clock
- clear_n  in  1  asynchronous, active-low reset
- start  in  1  request to execute; sampled only in IDLE
- opcode  in  5  operation code, latched on acceptance
- ra, rb, rc  in  4 each  destination, first source and second source register numbers, latched on acceptance
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on successful completion
- illegal  out  1  one-cycle pulse when an unsupported opcode is accepted
- rsel  out  4  register number for the rout/rin strobes
- rout  out  1  selected register drives the bus
- rin  out  1  selected register loads from the bus
- yin  out  1  Y register loads from the bus
- zin  out  1  Z register loads the ALU result
- zlo_out  out  1  Z-low drives the bus
- alu_op  out  10  one-hot ALU select: bit0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHR, 5 SHL, 6 ROR, 7 ROL, 8 NEG, 9 NOT

## Operation

Opcode map:
- Binary: ADD 00011, SUB 00100, AND 00101, OR 00110, SHR 00111, SHL 01001, ROR 01010, ROL 01011.
- Unary, operand in Rb, Rc ignored: NEG 10001, NOT 10010.
- Every other code is illegal.

States: IDLE, TY, TZ, TW, DONE, ERR. All outputs are Moore-decoded from the state register and the latched fields. Any strobe not listed for a state is 0.

- **IDLE**
  - On start=1, latch opcode, ra, rb and rc.
  - Binary opcode -> TY. Unary opcode -> TZ. Illegal opcode -> ERR.
  - With start=0, stay in IDLE.
- **TY:** rsel=rb, rout=1, yin=1. Next state TZ.
- **TZ**
  - Binary: rsel=rc. Unary: rsel=rb.
  - rout=1, zin=1, and alu_op carries exactly the one bit for the latched opcode.
  - Next state TW.
- **TW:** rsel=ra, zlo_out=1, rin=1. Next state DONE.
- **DONE:** done=1. Next state IDLE.
- **ERR:** illegal=1. Next state IDLE. No rout, rin, yin or zin is ever asserted on the illegal path.

Other rules:
- alu_op is 0 in every state except TZ; at most one bit is ever set.
- start is ignored while busy=1. Inputs changing after acceptance have no effect.
- ra=0 is written like any other register; R0 special handling is outside this block.
- ra equal to rb or rc is legal. The source is read in TY/TZ, before the TW write.

## Timing

Reset and idle values:
- clear_n low immediately forces state IDLE and all outputs 0, including mid-operation. A partially sequenced op is abandoned with no rin pulse.
- Latched fields reset to 0.
- Outputs in IDLE: busy=0, every strobe 0, rsel=0.

Latency, with start sampled at rising edge k:
- Binary: TY in cycle k+1, TZ k+2, TW k+3, DONE k+4.
- Unary: TZ k+1, TW k+2, DONE k+3.
- Illegal: ERR k+1.

Issue rate:
- DONE and ERR do not accept start.
- The earliest next acceptance is the edge ending the first IDLE cycle after them.
- Back-to-back binary ops therefore issue every 5 cycles; unary every 4; illegal every 2.

busy rises in the first cycle after acceptance and falls in the cycle after DONE/ERR.

## Test plan

- **Reset:** hold clear_n=0 for 3 cycles with start=1. Required: busy, done, illegal and all strobes stay 0; after release with start=0, the block stays IDLE.
- **Binary ADD:** opcode=00011, ra=3, rb=4, rc=5, start pulsed for one cycle.
  - Cycle +1: rsel=4, rout, yin.
  - Cycle +2: rsel=5, rout, zin, alu_op=10'b0000000001.
  - Cycle +3: rsel=3, zlo_out, rin.
  - Cycle +4: done=1. Then busy=0.
- **Unary NOT:** opcode=10010, ra=7, rb=2.
  - TY is skipped; cycle +1: rsel=2, rout, zin, alu_op=10'b1000000000.
  - Cycle +2: rsel=7, rin.
  - Cycle +3: done=1.
- **Illegal opcode 01111:** required response is illegal=1 in cycle +1 only, and no strobe is asserted at any time. An AND (00101) issued immediately after is accepted 2 cycles after the first start and completes normally.
- **Busy and overlap:** hold start=1 continuously with alternating opcodes and fields.
  - Opcode and fields change during busy; the running op keeps its latched values.
  - Successive binary ops are accepted exactly 5 cycles apart.
  - alu_op is never multi-hot.
- **Reset mid-op:** assert clear_n=0 asynchronously, between edges, during TZ of a SUB. Required: all outputs drop before the next edge; no rin or done follows; a fresh OR (00110) after release runs a full sequence.

Source files
------------

// File: rtl/alu_sequencer.sv
// Control sequencer for one register-to-register ALU instruction on the shared-bus datapath.
// Walks operand fetch into Y, ALU evaluation into Z, and write-back of Z-low into Ra.
module alu_sequencer (
    input  logic       clock,
    input  logic       clear_n,
    input  logic       start,
    input  logic [4:0] opcode,
    input  logic [3:0] ra,
    input  logic [3:0] rb,
    input  logic [3:0] rc,
    output logic       busy,
    output logic       done,
    output logic       illegal,
    output logic [3:0] rsel,
    output logic       rout,
    output logic       rin,
    output logic       yin,
    output logic       zin,
    output logic       zlo_out,
    output logic [9:0] alu_op,
    output logic [2:0] dbg_state
);

    // Handshake: start is accepted on a rising edge only while busy=0 (IDLE);
    // busy stays high until the cycle after the done or illegal pulse.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TY   = 3'd1,
        S_TZ   = 3'd2,
        S_TW   = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] opcode_q;
    logic [3:0] ra_q, rb_q, rc_q;
    logic       accept;
    logic       in_legal;
    logic       in_unary;
    logic [9:0] op_onehot_q;
    logic       unary_q;

    function automatic logic [9:0] decode_op(input logic [4:0] op);
        logic [9:0] sel;
        sel = 10'b0;
        case (op)
            5'b00011: sel = 10'b0000000001;
            5'b00100: sel = 10'b0000000010;
            5'b00101: sel = 10'b0000000100;
            5'b00110: sel = 10'b0000001000;
            5'b00111: sel = 10'b0000010000;
            5'b01001: sel = 10'b0000100000;
            5'b01010: sel = 10'b0001000000;
            5'b01011: sel = 10'b0010000000;
            5'b10001: sel = 10'b0100000000;
            5'b10010: sel = 10'b1000000000;
            default:  sel = 10'b0;
        endcase
        return sel;
    endfunction

    function automatic logic is_unary(input logic [4:0] op);
        return (op == 5'b10001) || (op == 5'b10010);
    endfunction

    assign accept      = (state_q == S_IDLE) && start;
    assign in_legal    = |decode_op(opcode);
    assign in_unary    = is_unary(opcode);
    assign op_onehot_q = decode_op(opcode_q);
    assign unary_q     = is_unary(opcode_q);
    assign dbg_state   = state_q;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Fields are captured only on acceptance so later input changes cannot disturb a running op.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            opcode_q <= 5'd0;
            ra_q     <= 4'd0;
            rb_q     <= 4'd0;
            rc_q     <= 4'd0;
        end else if (accept) begin
            opcode_q <= opcode;
            ra_q     <= ra;
            rb_q     <= rb;
            rc_q     <= rc;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (!in_legal) begin
                        state_d = S_ERR;
                    end else if (in_unary) begin
                        state_d = S_TZ;
                    end else begin
                        state_d = S_TY;
                    end
                end
            end
            S_TY:    state_d = S_TZ;
            S_TZ:    state_d = S_TW;
            S_TW:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        illegal = 1'b0;
        rsel    = 4'd0;
        rout    = 1'b0;
        rin     = 1'b0;
        yin     = 1'b0;
        zin     = 1'b0;
        zlo_out = 1'b0;
        alu_op  = 10'b0;
        case (state_q)
            S_IDLE: begin
            end
            S_TY: begin
                busy = 1'b1;
                rsel = rb_q;
                rout = 1'b1;
                yin  = 1'b1;
            end
            S_TZ: begin
                busy   = 1'b1;
                // Unary ops take their single operand from Rb; Rc is ignored.
                rsel   = unary_q ? rb_q : rc_q;
                rout   = 1'b1;
                zin    = 1'b1;
                alu_op = op_onehot_q;
            end
            S_TW: begin
                busy    = 1'b1;
                rsel    = ra_q;
                zlo_out = 1'b1;
                rin     = 1'b1;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            S_ERR: begin
                busy    = 1'b1;
                illegal = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: reset, binary/unary/illegal sequences, overlap and mid-op reset.
// Outputs are packed {busy,done,illegal,rsel,rout,rin,yin,zin,zlo_out,alu_op} and compared per cycle.
module tb_alu_sequencer;

    logic       clock;
    logic       clear_n;
    logic       start;
    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       busy, done, illegal;
    logic [3:0] rsel;
    logic       rout, rin, yin, zin, zlo_out;
    logic [9:0] alu_op;
    logic [2:0] dbg_state;
    logic [21:0] obs;

    int checks = 0;
    int errors = 0;

    alu_sequencer dut (
        .clock     (clock),
        .clear_n   (clear_n),
        .start     (start),
        .opcode    (opcode),
        .ra        (ra),
        .rb        (rb),
        .rc        (rc),
        .busy      (busy),
        .done      (done),
        .illegal   (illegal),
        .rsel      (rsel),
        .rout      (rout),
        .rin       (rin),
        .yin       (yin),
        .zin       (zin),
        .zlo_out   (zlo_out),
        .alu_op    (alu_op),
        .dbg_state (dbg_state)
    );

    assign obs = {busy, done, illegal, rsel, rout, rin, yin, zin, zlo_out, alu_op};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [21:0] ev(input logic b, input logic d, input logic il,
                                       input logic [3:0] rs, input logic ro, input logic ri,
                                       input logic yi, input logic zi, input logic zl,
                                       input logic [9:0] alu);
        return {b, d, il, rs, ro, ri, yi, zi, zl, alu};
    endfunction

    task automatic set_op(input logic [4:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c);
        opcode = op;
        ra     = a;
        rb     = b;
        rc     = c;
    endtask

    task automatic test_reset();
        clear_n = 1'b0;
        start   = 1'b1;
        set_op(5'b00011, 4'd1, 4'd2, 4'd3);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            checks++;
            if (obs !== 22'd0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got %h want %h", c, obs, 22'd0);
            end
        end
        clear_n = 1'b1;
        start   = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            checks++;
            if (obs !== 22'd0 || dbg_state !== 3'd0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: got %h/%0d want %h/0", c, obs, dbg_state, 22'd0);
            end
        end
    endtask

    task automatic test_binary_add();
        logic [21:0] exp [5];
        exp[0] = ev(1, 0, 0, 4'd4, 1, 0, 1, 0, 0, 10'b0);
        exp[1] = ev(1, 0, 0, 4'd5, 1, 0, 0, 1, 0, 10'b0000000001);
        exp[2] = ev(1, 0, 0, 4'd3, 0, 1, 0, 0, 1, 10'b0);
        exp[3] = ev(1, 1, 0, 4'd0, 0, 0, 0, 0, 0, 10'b0);
        exp[4] = 22'd0;
        set_op(5'b00011, 4'd3, 4'd4, 4'd5);
        start = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (c == 0) start = 1'b0;
            checks++;
            if (obs !== exp[c]) begin
                errors++;
                $display("FAIL add cycle +%0d: got %h want %h", c + 1, obs, exp[c]);
            end
        end
    endtask

    task automatic test_unary_not();
        logic [21:0] exp [4];
        exp[0] = ev(1, 0, 0, 4'd2, 1, 0, 0, 1, 0, 10'b1000000000);
        exp[1] = ev(1, 0, 0, 4'd7, 0, 1, 0, 0, 1, 10'b0);
        exp[2] = ev(1, 1, 0, 4'd0, 0, 0, 0, 0, 0, 10'b0);
        exp[3] = 22'd0;
        set_op(5'b10010, 4'd7, 4'd2, 4'd9);
        start = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (c == 0) start = 1'b0;
            checks++;
            if (obs !== exp[c]) begin
                errors++;
                $display("FAIL not cycle +%0d: got %h want %h", c + 1, obs, exp[c]);
            end
        end
    endtask

    task automatic test_illegal_then_and();
        logic [21:0] exp [7];
        exp[0] = ev(1, 0, 1, 4'd0, 0, 0, 0, 0, 0, 10'b0);
        exp[1] = 22'd0;
        exp[2] = ev(1, 0, 0, 4'd2, 1, 0, 1, 0, 0, 10'b0);
        exp[3] = ev(1, 0, 0, 4'd3, 1, 0, 0, 1, 0, 10'b0000000100);
        exp[4] = ev(1, 0, 0, 4'd1, 0, 1, 0, 0, 1, 10'b0);
        exp[5] = ev(1, 1, 0, 4'd0, 0, 0, 0, 0, 0, 10'b0);
        exp[6] = 22'd0;
        set_op(5'b01111, 4'd6, 4'd6, 4'd6);
        start = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clock);
            if (c == 0) set_op(5'b00101, 4'd1, 4'd2, 4'd3);
            if (c == 2) start = 1'b0;
            checks++;
            if (obs !== exp[c]) begin
                errors++;
                $display("FAIL illegal_and cycle +%0d: got %h want %h", c + 1, obs, exp[c]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] ops [3];
        logic [3:0] fa [3];
        logic [3:0] fb [3];
        logic [3:0] fc [3];
        logic [9:0] sel [3];
        logic [21:0] exp;
        ops[0] = 5'b00100; fa[0] = 4'd1; fb[0] = 4'd2; fc[0] = 4'd3; sel[0] = 10'b0000000010;
        ops[1] = 5'b01001; fa[1] = 4'd4; fb[1] = 4'd5; fc[1] = 4'd6; sel[1] = 10'b0000100000;
        ops[2] = 5'b00011; fa[2] = 4'd8; fb[2] = 4'd9; fc[2] = 4'd10; sel[2] = 10'b0000000001;
        set_op(ops[0], fa[0], fb[0], fc[0]);
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < 5; c++) begin
                @(negedge clock);
                case (c)
                    0:       exp = ev(1, 0, 0, fb[i], 1, 0, 1, 0, 0, 10'b0);
                    1:       exp = ev(1, 0, 0, fc[i], 1, 0, 0, 1, 0, sel[i]);
                    2:       exp = ev(1, 0, 0, fa[i], 0, 1, 0, 0, 1, 10'b0);
                    3:       exp = ev(1, 1, 0, 4'd0, 0, 0, 0, 0, 0, 10'b0);
                    default: exp = 22'd0;
                endcase
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL overlap op %0d cycle +%0d: got %h want %h", i, c + 1, obs, exp);
                end
                checks++;
                if ($countones(alu_op) > 1) begin
                    errors++;
                    $display("FAIL onehot op %0d cycle +%0d: got %b want at most one bit", i, c + 1, alu_op);
                end
                if (c < 4) begin
                    if (c % 2 == 0) set_op(5'b10010, 4'd15, 4'd14, 4'd13);
                    else            set_op(5'b01011, 4'd12, 4'd11, 4'd10);
                end else if (i < 2) begin
                    set_op(ops[i + 1], fa[i + 1], fb[i + 1], fc[i + 1]);
                end else begin
                    start = 1'b0;
                end
            end
        end
    endtask

    task automatic test_reset_mid_op();
        logic [21:0] exp [5];
        set_op(5'b00100, 4'd1, 4'd2, 4'd3);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checks++;
        if (obs !== ev(1, 0, 0, 4'd2, 1, 0, 1, 0, 0, 10'b0)) begin
            errors++;
            $display("FAIL midreset_ty: got %h want %h", obs, ev(1, 0, 0, 4'd2, 1, 0, 1, 0, 0, 10'b0));
        end
        @(posedge clock);
        #2;
        checks++;
        if (obs !== ev(1, 0, 0, 4'd3, 1, 0, 0, 1, 0, 10'b0000000010)) begin
            errors++;
            $display("FAIL midreset_tz: got %h want %h", obs, ev(1, 0, 0, 4'd3, 1, 0, 0, 1, 0, 10'b0000000010));
        end
        #1 clear_n = 1'b0;
        #1;
        checks++;
        if (obs !== 22'd0) begin
            errors++;
            $display("FAIL midreset_async: got %h want %h", obs, 22'd0);
        end
        @(negedge clock);
        @(negedge clock);
        clear_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            checks++;
            if (obs !== 22'd0) begin
                errors++;
                $display("FAIL midreset_quiet cycle %0d: got %h want %h", c, obs, 22'd0);
            end
        end
        exp[0] = ev(1, 0, 0, 4'd6, 1, 0, 1, 0, 0, 10'b0);
        exp[1] = ev(1, 0, 0, 4'd7, 1, 0, 0, 1, 0, 10'b0000001000);
        exp[2] = ev(1, 0, 0, 4'd5, 0, 1, 0, 0, 1, 10'b0);
        exp[3] = ev(1, 1, 0, 4'd0, 0, 0, 0, 0, 0, 10'b0);
        exp[4] = 22'd0;
        set_op(5'b00110, 4'd5, 4'd6, 4'd7);
        start = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (c == 0) start = 1'b0;
            checks++;
            if (obs !== exp[c]) begin
                errors++;
                $display("FAIL or_after_reset cycle +%0d: got %h want %h", c + 1, obs, exp[c]);
            end
        end
    endtask

    initial begin
        clear_n = 1'b0;
        start   = 1'b0;
        set_op(5'd0, 4'd0, 4'd0, 4'd0);
        test_reset();
        test_binary_add();
        test_unary_not();
        test_illegal_then_and();
        test_back_to_back();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
